// File: rtl/ub_read_streamer_if.sv
// rtl/ub_read_streamer_if.sv - command, buffer read port and row stream bundle for ub_read_streamer
interface ub_read_streamer_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 9
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef UB_RD_STRIDE_EN
   logic [ADDR_WIDTH-1:0] cmd_stride;
`endif
   logic                  bram_enb;
   logic [ADDR_WIDTH-1:0] bram_addrb;
   logic [DATA_WIDTH-1:0] bram_doutb;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  busy;
   logic                  done;

   // streamer side
   modport master (
`ifdef UB_RD_STRIDE_EN
      input  cmd_stride,
`endif
      input  cmd_valid, cmd_addr, cmd_len,
      output cmd_ready,
      output bram_enb, bram_addrb,
      input  bram_doutb,
      output m_valid, m_data, m_last,
      input  m_ready,
      output busy, done
   );

   // command source, buffer and row consumer side
   modport slave (
`ifdef UB_RD_STRIDE_EN
      output cmd_stride,
`endif
      output cmd_valid, cmd_addr, cmd_len,
      input  cmd_ready,
      input  bram_enb, bram_addrb,
      output bram_doutb,
      input  m_valid, m_data, m_last,
      output m_ready,
      input  busy, done
   );
endinterface

// File: rtl/ub_read_streamer.sv
// rtl/ub_read_streamer.sv - unified buffer burst reader with credit-controlled output FIFO (optional UB_RD_STRIDE_EN)
module ub_read_streamer #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 9,
   parameter int FIFO_DEPTH = 2
) (
   input logic clk,
   input logic reset_n,
   ub_read_streamer_if.master ub
);

   // The credit rule counts only the read currently on bram_enb; the older
   // read whose data sits on bram_doutb is about to land regardless, so the
   // storage carries one slot more than FIFO_DEPTH to give it a home.
   localparam int NENT = FIFO_DEPTH + 1;
   localparam int PW   = (NENT > 1) ? $clog2(NENT) : 1;
   localparam int CW   = $clog2(NENT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state_q;
   logic                  enb_q;
   logic                  enb_last_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  issued_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  land_q;
   logic                  land_last_q;
   logic [DATA_WIDTH-1:0] mem_q [NENT];
   logic                  last_mem_q [NENT];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;

   logic                  pop;
   logic                  credit_ok;
   logic                  drain_done;
   logic [CW:0]           occ_w;
   logic [CW:0]           lim_w;
   logic [ADDR_WIDTH-1:0] cmd_stride_w;

`ifdef UB_RD_STRIDE_EN
   assign cmd_stride_w = ub.cmd_stride;
`else
   assign cmd_stride_w = ADDR_WIDTH'(1);
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(NENT - 1)) ? '0 : p + PW'(1);
   endfunction

   // credit, drain-complete and FIFO occupancy next-state
   always_comb begin
      pop        = (count_q != '0) && ub.m_ready;
      occ_w      = {1'b0, count_q} + (CW + 1)'(enb_q);
      lim_w      = (CW + 1)'(FIFO_DEPTH) + (CW + 1)'(pop);
      credit_ok  = occ_w < lim_w;
      drain_done = !enb_q && !land_q && (count_q == CW'(pop));
      count_d    = count_q;
      case ({land_q, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // burst FSM: command capture, read issue under credit, completion pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         enb_q      <= 1'b0;
         enb_last_q <= 1'b0;
         addr_q     <= '0;
         stride_q   <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               enb_q      <= 1'b0;
               enb_last_q <= 1'b0;
               if (ub.cmd_valid) begin
                  addr_q   <= ub.cmd_addr;
                  stride_q <= cmd_stride_w;
                  len_q    <= ub.cmd_len;
                  busy_q   <= 1'b1;
                  if (ub.cmd_len == '0) begin
                     done_q  <= 1'b1;
                     state_q <= DRAIN;
                  end else begin
                     enb_q      <= 1'b1;
                     enb_last_q <= (ub.cmd_len == LEN_WIDTH'(1));
                     issued_q   <= LEN_WIDTH'(1);
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (issued_q == len_q) begin
                  enb_q      <= 1'b0;
                  enb_last_q <= 1'b0;
                  state_q    <= DRAIN;
               end else if (credit_ok) begin
                  enb_q      <= 1'b1;
                  enb_last_q <= (issued_q + LEN_WIDTH'(1) == len_q);
                  addr_q     <= addr_q + stride_q;
                  issued_q   <= issued_q + LEN_WIDTH'(1);
               end else begin
                  enb_q      <= 1'b0;
                  enb_last_q <= 1'b0;
               end
            end
            DRAIN: begin
               enb_q      <= 1'b0;
               enb_last_q <= 1'b0;
               if (done_q) begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (drain_done) begin
                  done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // output FIFO: rows land one cycle after their read enable, pop on accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         land_q      <= 1'b0;
         land_last_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < NENT; i++) begin
            mem_q[i]      <= '0;
            last_mem_q[i] <= 1'b0;
         end
      end else begin
         land_q      <= enb_q;
         land_last_q <= enb_last_q;
         if (land_q) begin
            mem_q[wr_ptr_q]      <= ub.bram_doutb;
            last_mem_q[wr_ptr_q] <= land_last_q;
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_d;
      end
   end

   assign ub.cmd_ready  = (state_q == IDLE);
   assign ub.bram_enb   = enb_q;
   assign ub.bram_addrb = addr_q;
   assign ub.m_valid    = (count_q != '0);
   assign ub.m_data     = mem_q[rd_ptr_q];
   assign ub.m_last     = (count_q != '0) && last_mem_q[rd_ptr_q];
   assign ub.busy       = busy_q;
   assign ub.done       = done_q;

endmodule
